// File: rtl/alu_pkg.sv
// Shared opcode encodings and default widths for the MIPS32 EX-stage ALU.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;

endpackage

// File: rtl/alu_shifter.sv
// Combinational right barrel shifter: one stage per amount bit, logical or arithmetic fill.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] amt_i,
  input  logic               arith_i,
  output logic [WIDTH-1:0]   y_o
);

  logic             fill;
  logic [WIDTH-1:0] stage [0:SHAMT_W];

  assign fill     = arith_i & a_i[WIDTH-1];
  assign stage[0] = a_i;

  // Stage i shifts by 2**i when amount bit i is set.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stage[i+1] = amt_i[i] ? {{S{fill}}, stage[i][WIDTH-1:S]} : stage[i];
  end

  assign y_o = stage[SHAMT_W];

endmodule

// File: rtl/alu32.sv
// 32-bit MIPS32 EX-stage ALU: combinational add/sub/logic/shift core plus one
// output register stage for result, flags and valid.
module alu32
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  input  logic             in_valid,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);

  logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
  logic        [WIDTH-1:0] shift_res;
  logic        [WIDTH-1:0] c_d, c_q;
  logic                    zero_d, zero_q;
  logic                    ovf_d, ovf_q;
  logic                    vld_q;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  assign a_s    = A;
  assign b_s    = B;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  alu_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .a_i    (A),
    .amt_i  (B[SHAMT_W-1:0]),
    .arith_i(ALUOp == OP_SRA),
    .y_o    (shift_res)
  );

  always_comb begin
    c_d   = '0;
    ovf_d = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        c_d   = sum_s;
        ovf_d = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        c_d   = diff_s;
        ovf_d = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_AND:         c_d = A & B;
      OP_OR:          c_d = A | B;
      OP_SRL, OP_SRA: c_d = shift_res;
      default:        c_d = '0;
    endcase
    zero_d = (c_d == '0);
  end

  // Output register: result/flags hold unless a valid op is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q    <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        c_q    <= c_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign C         = c_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vector table, hold/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_alu32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  ALUOp;
  logic        in_valid;
  logic [31:0] C;
  logic        zero, overflow, out_valid;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu32 dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .in_valid (in_valid),
    .C        (C),
    .zero     (zero),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_c;
    logic        exp_z;
    logic        exp_o;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: wide signed arithmetic decides overflow by range, not sign bits.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic [31:0] c, output logic o);
    longint             wide;
    logic signed [31:0] as;
    int unsigned        sh;
    sh = int'(b % 32);
    as = a;
    c  = 32'h0;
    o  = 1'b0;
    case (op)
      3'd0: begin
        wide = longint'($signed(a)) + longint'($signed(b));
        c    = wide[31:0];
        o    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd1: begin
        wide = longint'($signed(a)) - longint'($signed(b));
        c    = wide[31:0];
        o    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd2: c = a & b;
      3'd3: c = a | b;
      3'd4: c = a >> sh;
      3'd5: begin
        as = as >>> sh;
        c  = as;
      end
      default: c = 32'h0;
    endcase
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic v);
    A = a; B = b; ALUOp = op; in_valid = v;
  endtask

  initial begin
    logic [31:0] mc, exp_c;
    logic        mo, exp_o, exp_z;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic        rv;

    vecs[0]  = '{32'h1,        32'h2,  3'd0, 32'h3,        1'b0, 1'b0};
    vecs[1]  = '{32'h3,        32'h2,  3'd1, 32'h1,        1'b0, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF, 32'h1,  3'd0, 32'h80000000, 1'b0, 1'b1};
    vecs[3]  = '{32'h80000000, 32'h1,  3'd1, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4]  = '{32'h4,        32'h1,  3'd2, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{32'h1,        32'h2,  3'd3, 32'h3,        1'b0, 1'b0};
    vecs[6]  = '{32'h1,        32'h2,  3'd4, 32'h0,        1'b1, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h4,  3'd4, 32'h08000000, 1'b0, 1'b0};
    vecs[8]  = '{32'h80000000, 32'h4,  3'd5, 32'hF8000000, 1'b0, 1'b0};
    vecs[9]  = '{32'hF0,       32'h24, 3'd4, 32'h0F,       1'b0, 1'b0};
    vecs[10] = '{32'h12345678, 32'h9,  3'd6, 32'h0,        1'b1, 1'b0};

    reset = 1'b1;
    drive(32'h0, 32'h0, 3'd0, 1'b0);
    #2;
    chk("reset_C", C, 32'h0);
    chk("reset_zero", {31'b0, zero}, 32'h1);
    chk("reset_ovf", {31'b0, overflow}, 32'h0);
    chk("reset_vld", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_C", i), C, vecs[i].exp_c);
      chk($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_z});
      chk($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].exp_o});
      chk($sformatf("vec%0d_vld", i), {31'b0, out_valid}, 32'h1);
    end

    // Hold after the reserved op: new operands but in_valid low.
    for (int i = 0; i < 3; i++) begin
      drive(32'h7FFFFFFF, 32'h1 + i, 3'd0, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_C", i), C, 32'h0);
      chk($sformatf("hold%0d_zero", i), {31'b0, zero}, 32'h1);
      chk($sformatf("hold%0d_ovf", i), {31'b0, overflow}, 32'h0);
      chk($sformatf("hold%0d_vld", i), {31'b0, out_valid}, 32'h0);
    end

    // Asynchronous reset between edges while ADD 5+5 streams.
    drive(32'd5, 32'd5, 3'd0, 1'b1);
    @(posedge clk); #1;
    chk("stream_C", C, 32'd10);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_C", C, 32'h0);
    chk("async_rst_zero", {31'b0, zero}, 32'h1);
    chk("async_rst_vld", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rst_held_C", C, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_C", C, 32'd10);
    chk("post_rst_zero", {31'b0, zero}, 32'h0);
    chk("post_rst_vld", {31'b0, out_valid}, 32'h1);

    // Randomized traffic; expected registers track the last valid op.
    exp_c = 32'd10; exp_z = 1'b0; exp_o = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFFFFFF;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      rop = 3'($urandom_range(0, 7));
      rv  = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rop, rv);
      if (rv) begin
        model(ra, rb, rop, mc, mo);
        exp_c = mc; exp_o = mo; exp_z = (mc == 32'h0);
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_C op%0d", i, rop), C, exp_c);
      chk($sformatf("rnd%0d_zero", i), {31'b0, zero}, {31'b0, exp_z});
      chk($sformatf("rnd%0d_ovf", i), {31'b0, overflow}, {31'b0, exp_o});
      chk($sformatf("rnd%0d_vld", i), {31'b0, out_valid}, {31'b0, rv});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit integer ALU for the MIPS32 single-cycle/pipelined datapath; executes the EX-stage arithmetic, logic and shift operation selected by a 3-bit opcode.
- Combinational compute core followed by one output register stage: result, flags and valid are registered on the rising clock edge.
- Consumers (mem/writeback) sample C one cycle after operands are presented.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, number of low bits of B used as the shift amount; equals log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all registered outputs.
- A  input  WIDTH  operand A; also the shifted value for shift ops.
- B  input  WIDTH  operand B; B[SHAMT_W-1:0] is the shift amount for shift ops.
- ALUOp  input  3  operation select.
- in_valid  input  1  operands/opcode valid this cycle.
- C  output  WIDTH  registered result.
- zero  output  1  registered; 1 when C == 0.
- overflow  output  1  registered; signed overflow for add/sub, 0 for other ops.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- ALUOp encoding:
  - 000 ADD: A + B, modulo 2^WIDTH.
  - 001 SUB: A - B, modulo 2^WIDTH.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 SRL: A logically shifted right by B[4:0], zero fill.
  - 101 SRA: A arithmetically shifted right by B[4:0], sign fill from A[31].
  - 110, 111: reserved; result 0, overflow 0.
- Shift amount: only B[4:0] is used; upper B bits are ignored. Shift by 0 returns A unchanged.
- Overflow:
  - ADD: set when A[31] == B[31] and result[31] != A[31].
  - SUB: set when A[31] != B[31] and result[31] != A[31].
  - Overflow never suppresses the result; C always holds the wrapped value.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on C/zero/overflow/out_valid after edge N.
- Register updates:
  - C, zero and overflow update only when in_valid = 1; otherwise they hold their previous values.
  - out_valid updates every cycle (out_valid <= in_valid).
- Back-to-back: a new operation may be issued every cycle; no stall or backpressure.
- Reset: asynchronous assert forces C = 0, zero = 1, overflow = 0, out_valid = 0 immediately, regardless of clk.
  - An operation in flight when reset asserts is discarded.
  - After deassertion, the first capture occurs at the next rising edge with in_valid = 1.
- No internal state other than the output registers; pure function of the sampled inputs.

Decomposition:
- Package alu_pkg: ALUOp localparams (OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_SRL = 3'd4, OP_SRA = 3'd5) and WIDTH/SHAMT_W defaults.
- One natural sub-module, alu_shifter: combinational 32-bit right shifter (logical/arithmetic select, 5-bit amount, log-stage barrel).
- Adder/subtractor, logic ops, result mux and flag logic stay in alu32 with the output register.

Test Plan:
- Arithmetic:
  - A=1, B=2, ALUOp=0, in_valid=1 -> next cycle C=3, zero=0, overflow=0, out_valid=1.
  - A=3, B=2, ALUOp=1 -> C=1.
  - A=0x7FFFFFFF, B=1, ALUOp=0 -> C=0x80000000, overflow=1.
  - A=0x80000000, B=1, ALUOp=1 -> C=0x7FFFFFFF, overflow=1.
- Logic: A=4, B=1, ALUOp=2 -> C=0, zero=1; A=1, B=2, ALUOp=3 -> C=3, zero=0.
- Shifts:
  - A=1, B=2, ALUOp=4 -> C=0.
  - A=0x80000000, B=4, ALUOp=4 -> C=0x08000000.
  - Same operands, ALUOp=5 -> C=0xF8000000.
  - A=0xF0, B=0x24, ALUOp=4 (uses amount 4) -> C=0x0F.
- Reserved/hold:
  - ALUOp=6 -> C=0, zero=1, overflow=0.
  - Then in_valid=0 with new operands for 3 cycles -> C, zero and overflow hold; out_valid=0.
- Reset mid-stream:
  - Issue ADD 5+5 every cycle, assert reset between edges -> C=0, zero=1, out_valid=0 immediately (asynchronous).
  - Release reset, issue ADD 5+5 -> C=10 after the next edge.
